// File: rtl/alu_sequencer.sv
// Instruction sequencer for a combinational 4-bit ALU: owns acc, carry and a 16x4 register file.
// Every instruction takes READ -> EXEC -> DONE after its handshake. instr_ready is high only in IDLE.
`timescale 1ns/1ps
module alu_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic [7:0] instr,
  output logic       instr_ready,
  output logic       done,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_sel,
  output logic       alu_cin,
  input  logic [3:0] alu_out,
  input  logic       alu_cout,
  output logic [3:0] acc,
  output logic       carry,
  input  logic [3:0] dbg_addr,
  output logic [3:0] dbg_data
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_DONE} state_t;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LDI  = 3'b001;
  localparam logic [2:0] OP_LD   = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_ADDI = 3'b110;
  localparam logic [2:0] OP_SETC = 3'b111;

  localparam logic [2:0] SEL_ADD  = 3'b011;
  localparam logic [2:0] SEL_XOR  = 3'b100;
  localparam logic [2:0] SEL_PASS = 3'b111;

  state_t      state_q, state_d;
  logic [7:0]  instr_q, instr_d;
  logic [3:0]  opnd_q, opnd_d;
  logic [3:0]  acc_q, acc_d;
  logic        carry_q, carry_d;
  logic [3:0]  rf_q [16];
  logic        rf_we;

  logic [2:0]  op;
  logic        f;
  logic [3:0]  n;

  assign op = instr_q[7:5];
  assign f  = instr_q[4];
  assign n  = instr_q[3:0];

  assign instr_ready = (state_q == S_IDLE) && !rst;
  assign done        = (state_q == S_DONE) && !rst;
  assign acc         = acc_q;
  assign carry       = carry_q;
  assign dbg_data    = rf_q[dbg_addr];

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    rf_we   = 1'b0;
    // Idle ALU select is pass-A so the ALU's undefined select codes are never presented.
    alu_sel = SEL_PASS;
    alu_a   = 4'h0;
    alu_b   = 4'h0;
    alu_cin = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (instr_valid && instr_ready) begin
          instr_d = instr;
          state_d = S_READ;
        end
      end
      S_READ: begin
        opnd_d  = rf_q[n];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_DONE;
        case (op)
          OP_LDI: begin
            alu_a = n;
            acc_d = alu_out;
          end
          OP_LD: begin
            alu_a = opnd_q;
            acc_d = alu_out;
          end
          OP_ADD: begin
            alu_sel = SEL_ADD;
            alu_a   = acc_q;
            alu_b   = opnd_q;
            alu_cin = f & carry_q;
            acc_d   = alu_out;
            carry_d = alu_cout;
          end
          OP_XOR: begin
            alu_sel = SEL_XOR;
            alu_a   = acc_q;
            alu_b   = opnd_q;
            acc_d   = alu_out;
          end
          OP_ST:   rf_we = 1'b1;
          OP_ADDI: begin
            alu_sel = SEL_ADD;
            alu_a   = acc_q;
            alu_b   = n;
            alu_cin = f & carry_q;
            acc_d   = alu_out;
            carry_d = alu_cout;
          end
          OP_SETC: carry_d = f;
          OP_NOP:  ;
          default: ;
        endcase
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      instr_q <= 8'h00;
      opnd_q  <= 4'h0;
      acc_q   <= 4'h0;
      carry_q <= 1'b0;
      for (int i = 0; i < 16; i++) rf_q[i] <= 4'h0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      if (rf_we) rf_q[n] <= acc_q;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural model of the 4-bit ALU on its ports.
`timescale 1ns/1ps
module tb_alu_sequencer;

  logic       clk;
  logic       rst;
  logic       instr_valid;
  logic [7:0] instr;
  logic       instr_ready;
  logic       done;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_sel;
  logic       alu_cin;
  logic [3:0] alu_out;
  logic       alu_cout;
  logic [3:0] acc;
  logic       carry;
  logic [3:0] dbg_addr;
  logic [3:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .done(done),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_cout(alu_cout),
    .acc(acc), .carry(carry), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU: 011 add, 100 xor, 111 pass A
  always_comb begin
    alu_out  = 4'h0;
    alu_cout = 1'b0;
    case (alu_sel)
      3'b011:  {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {4'h0, alu_cin};
      3'b100:  alu_out = alu_a ^ alu_b;
      3'b111:  alu_out = alu_a;
      default: alu_out = 4'h0;
    endcase
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts and ends at a negedge with the DUT in IDLE.
  task automatic run_instr(input string tag, input logic [7:0] ins,
                           input logic [2:0] exp_sel, input logic exp_cin,
                           input logic [3:0] exp_dbg_exec);
    instr_valid = 1'b1;
    instr       = ins;
    check({tag, ".ready_idle"}, {7'h0, instr_ready}, 8'h1);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    check({tag, ".read_ready"}, {7'h0, instr_ready}, 8'h0);
    check({tag, ".read_done"}, {7'h0, done}, 8'h0);
    check({tag, ".read_sel"}, {5'h0, alu_sel}, 8'h7);
    @(negedge clk);
    check({tag, ".exec_done"}, {7'h0, done}, 8'h0);
    check({tag, ".exec_sel"}, {5'h0, alu_sel}, {5'h0, exp_sel});
    check({tag, ".exec_cin"}, {7'h0, alu_cin}, {7'h0, exp_cin});
    check({tag, ".exec_dbg"}, {4'h0, dbg_data}, {4'h0, exp_dbg_exec});
    @(negedge clk);
    check({tag, ".done_pulse"}, {7'h0, done}, 8'h1);
    check({tag, ".done_ready"}, {7'h0, instr_ready}, 8'h0);
    @(negedge clk);
    check({tag, ".done_clear"}, {7'h0, done}, 8'h0);
  endtask

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = 8'h00;
    dbg_addr    = 4'h0;

    // Reset
    @(negedge clk);
    @(negedge clk);
    check("rst.ready_low", {7'h0, instr_ready}, 8'h0);
    check("rst.done_low", {7'h0, done}, 8'h0);
    check("rst.alu_sel", {5'h0, alu_sel}, 8'h7);
    rst = 1'b0;
    #1;
    check("rst.ready_after", {7'h0, instr_ready}, 8'h1);
    check("rst.acc", {4'h0, acc}, 8'h0);
    check("rst.carry", {7'h0, carry}, 8'h0);
    check("rst.alu_a", {4'h0, alu_a}, 8'h0);
    check("rst.alu_b", {4'h0, alu_b}, 8'h0);
    check("rst.alu_cin", {7'h0, alu_cin}, 8'h0);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = i[3:0];
      #1;
      check("rst.rf", {4'h0, dbg_data}, 8'h0);
    end
    @(negedge clk);

    // Load and add
    dbg_addr = 4'd3;
    run_instr("ldi9", 8'h29, 3'b111, 1'b0, 4'h0);
    check("ldi9.acc", {4'h0, acc}, 8'h9);
    run_instr("st_r3", 8'hA3, 3'b111, 1'b0, 4'h0);
    check("st_r3.rf", {4'h0, dbg_data}, 8'h9);
    run_instr("ldi8", 8'h28, 3'b111, 1'b0, 4'h9);
    run_instr("add_r3", 8'h63, 3'b011, 1'b0, 4'h9);
    check("add_r3.acc", {4'h0, acc}, 8'h1);
    check("add_r3.carry", {7'h0, carry}, 8'h1);

    // Add with carry-in
    run_instr("addi5c", 8'hD5, 3'b011, 1'b1, 4'h9);
    check("addi5c.acc", {4'h0, acc}, 8'h7);
    check("addi5c.carry", {7'h0, carry}, 8'h0);
    run_instr("addiF", 8'hCF, 3'b011, 1'b0, 4'h9);
    check("addiF.acc", {4'h0, acc}, 8'h6);
    check("addiF.carry", {7'h0, carry}, 8'h1);

    // SETC and XOR
    dbg_addr = 4'd0;
    run_instr("setc0", 8'hE0, 3'b111, 1'b0, 4'h0);
    check("setc0.carry", {7'h0, carry}, 8'h0);
    check("setc0.acc", {4'h0, acc}, 8'h6);
    run_instr("setc1", 8'hF0, 3'b111, 1'b0, 4'h0);
    check("setc1.carry", {7'h0, carry}, 8'h1);
    run_instr("ldiA", 8'h2A, 3'b111, 1'b0, 4'h0);
    run_instr("st_r0", 8'hA0, 3'b111, 1'b0, 4'h0);
    check("st_r0.rf", {4'h0, dbg_data}, 8'hA);
    run_instr("ldi6", 8'h26, 3'b111, 1'b0, 4'hA);
    run_instr("xor_r0", 8'h80, 3'b100, 1'b0, 4'hA);
    check("xor_r0.acc", {4'h0, acc}, 8'hC);
    check("xor_r0.carry", {7'h0, carry}, 8'h1);
    run_instr("nop", 8'h00, 3'b111, 1'b0, 4'hA);
    check("nop.acc", {4'h0, acc}, 8'hC);
    run_instr("ld_r3", 8'h43, 3'b111, 1'b0, 4'hA);
    check("ld_r3.acc", {4'h0, acc}, 8'h9);

    // Held valid with changing instr: only the IDLE-edge instruction runs
    instr_valid = 1'b1;
    instr       = 8'h22;
    @(posedge clk);
    @(negedge clk);
    instr = 8'h27;
    check("hold.read_ready", {7'h0, instr_ready}, 8'h0);
    @(negedge clk);
    instr = 8'h25;
    check("hold.exec_ready", {7'h0, instr_ready}, 8'h0);
    check("hold.exec_a", {4'h0, alu_a}, 8'h2);
    @(negedge clk);
    instr = 8'hE0;
    check("hold.done_ready", {7'h0, instr_ready}, 8'h0);
    check("hold.done", {7'h0, done}, 8'h1);
    @(negedge clk);
    instr_valid = 1'b0;
    check("hold.idle_ready", {7'h0, instr_ready}, 8'h1);
    check("hold.acc", {4'h0, acc}, 8'h2);
    check("hold.carry", {7'h0, carry}, 8'h1);
    @(negedge clk);

    // Reset abort during EXEC
    run_instr("ldi4", 8'h24, 3'b111, 1'b0, 4'hA);
    check("ldi4.acc", {4'h0, acc}, 8'h4);
    instr_valid = 1'b1;
    instr       = 8'h2B;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check("abort.exec_a", {4'h0, alu_a}, 8'hB);
    rst = 1'b1;
    @(negedge clk);
    check("abort.done", {7'h0, done}, 8'h0);
    check("abort.ready_rst", {7'h0, instr_ready}, 8'h0);
    check("abort.acc", {4'h0, acc}, 8'h0);
    check("abort.rf0", {4'h0, dbg_data}, 8'h0);
    rst = 1'b0;
    #1;
    check("abort.ready", {7'h0, instr_ready}, 8'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort.no_done", {7'h0, done}, 8'h0);
    end
    check("abort.acc_final", {4'h0, acc}, 8'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
